// File: rtl/guess_keypad_if.sv
// Keypad symbol interface: raw button inputs toward the keypad, buffered symbols toward the game core.
interface guess_keypad_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    i_btn;
  logic          i_btn_enter;
  logic          i_clr_ovf;
  logic          i_sym_ready;
  logic          o_sym_valid;
  logic [1:0]    o_sym_code;
  logic          o_sym_is_enter;
  logic [CW-1:0] o_sym_count;
  logic          o_overflow;

  modport master (
    output i_btn, i_btn_enter, i_clr_ovf, i_sym_ready,
    input  o_sym_valid, o_sym_code, o_sym_is_enter, o_sym_count, o_overflow
  );

  modport slave (
    input  i_btn, i_btn_enter, i_clr_ovf, i_sym_ready,
    output o_sym_valid, o_sym_code, o_sym_is_enter, o_sym_count, o_overflow
  );
endinterface

// File: rtl/guess_keypad.sv
// Keypad front end: synchronize and debounce 5 buttons, emit one symbol per press into a small FIFO.
//   state     | meaning
//   ST_ARMED  | all debounced keys released; next press produces a symbol
//   ST_LOCKED | a symbol was taken for the current press; wait for full release
module guess_keypad #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  guess_keypad_if.slave bus
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [15:0]   DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

  typedef enum logic {ST_ARMED = 1'b0, ST_LOCKED = 1'b1} state_t;

  logic [4:0]    w_raw;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic [4:0]    w_deb;
  logic          w_any;
  logic          w_event;
  logic [2:0]    w_key;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_push;
  logic [2:0]    r_push_key;
  logic [2:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic          w_drop;
  logic          w_valid;
  logic [2:0]    w_head;

  // bit 4 is enter, bits 0..3 are digit keys I1..I4
  assign w_raw = {bus.i_btn_enter, bus.i_btn};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_deb
    logic [15:0] r_cnt;
    logic        r_bit;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        r_cnt <= '0;
        r_bit <= 1'b0;
      end else if (r_sync2[g] == r_bit) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt <= '0;
        r_bit <= r_sync2[g];
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end

    assign w_deb[g] = r_bit;
  end

  assign w_any = |w_deb;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_ARMED;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARMED:  if (w_any)  w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (!w_any) w_state_nxt = ST_ARMED;
      default:   w_state_nxt = ST_ARMED;
    endcase
  end

  always_comb begin
    w_event = 1'b0;
    if (r_state == ST_ARMED) w_event = w_any;
  end

  // enter is the lowest priority; its code field is always 0
  always_comb begin
    w_key = 3'b100;
    if      (w_deb[0]) w_key = 3'b000;
    else if (w_deb[1]) w_key = 3'b001;
    else if (w_deb[2]) w_key = 3'b010;
    else if (w_deb[3]) w_key = 3'b011;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_push     <= 1'b0;
      r_push_key <= '0;
    end else begin
      r_push     <= w_event;
      r_push_key <= w_key;
    end
  end

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & bus.i_sym_ready;
  assign w_full  = (r_count == FULL);
  assign w_wr    = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= r_push_key;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)             r_ovf <= 1'b1;
      else if (bus.i_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign w_head             = r_mem[r_rd];
  assign bus.o_sym_valid    = w_valid;
  assign bus.o_sym_code     = w_valid ? w_head[1:0] : 2'b00;
  assign bus.o_sym_is_enter = w_valid & w_head[2];
  assign bus.o_sym_count    = r_count;
  assign bus.o_overflow     = r_ovf;
endmodule

// File: tb/tb_guess_keypad.sv
// Bench for guess_keypad: queue-based keypad model checked every cycle, directed scenarios, random presses.
module tb_guess_keypad;
  localparam int DB    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  guess_keypad_if #(.FIFO_DEPTH(DEPTH)) kb ();

  guess_keypad #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (kb)
  );

  int total = 0;
  int bad   = 0;

  // model: synchronizer delay, debounce as "last DB samples all disagree", symbol queue
  logic [4:0] m_s1, m_s2, m_deb;
  logic [4:0] m_hist[$];
  bit         m_locked, m_pend, m_ovf;
  logic [2:0] m_pend_key;
  logic [2:0] m_q[$];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    m_hist.delete();
    m_q.delete();
    m_locked = 0; m_pend = 0; m_ovf = 0; m_pend_key = '0;
  endtask

  task automatic model_step();
    bit drop;
    bit anyk;
    logic [4:0] raw;
    raw = {kb.i_btn_enter, kb.i_btn};
    drop = 0;
    if (m_q.size() != 0 && kb.i_sym_ready) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend_key);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (kb.i_clr_ovf) m_ovf = 0;
    anyk = |m_deb;
    m_pend = anyk && !m_locked;
    if (m_pend) begin
      m_pend_key = 3'b100;
      for (int k = 3; k >= 0; k--) if (m_deb[k]) m_pend_key = 3'(k);
    end
    m_locked = anyk;
    m_hist.push_back(m_s2);
    if (m_hist.size() > DB) void'(m_hist.pop_front());
    if (m_hist.size() == DB) begin
      for (int k = 0; k < 5; k++) begin
        bit all_diff;
        all_diff = 1;
        foreach (m_hist[j]) if (m_hist[j][k] == m_deb[k]) all_diff = 0;
        if (all_diff) m_deb[k] = ~m_deb[k];
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  always @(posedge clk) begin
    if (reset) model_clear();
    else       model_step();
  end

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", kb.o_sym_valid, 0);
      chk("rst_count", kb.o_sym_count, 0);
      chk("rst_code",  kb.o_sym_code, 0);
      chk("rst_enter", kb.o_sym_is_enter, 0);
      chk("rst_ovf",   kb.o_overflow, 0);
    end else begin
      int  ev;
      int  ec;
      int  ee;
      ev = (m_q.size() != 0) ? 1 : 0;
      ec = ev ? int'(m_q[0][1:0]) : 0;
      ee = ev ? int'(m_q[0][2]) : 0;
      chk("mdl_valid", kb.o_sym_valid, ev);
      chk("mdl_count", kb.o_sym_count, m_q.size());
      chk("mdl_code",  kb.o_sym_code, ec);
      chk("mdl_enter", kb.o_sym_is_enter, ee);
      chk("mdl_ovf",   kb.o_overflow, int'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input logic [4:0] keys);
    {kb.i_btn_enter, kb.i_btn} = keys;
    step(12);
    {kb.i_btn_enter, kb.i_btn} = '0;
    step(10);
  endtask

  task automatic pop1();
    kb.i_sym_ready = 1'b1;
    step(1);
    kb.i_sym_ready = 1'b0;
  endtask

  initial begin
    int budget;
    int exp_codes[4];
    kb.i_btn = '0; kb.i_btn_enter = 1'b0; kb.i_clr_ovf = 1'b0; kb.i_sym_ready = 1'b0;
    step(2);
    chk("reset_count", kb.o_sym_count, 0);

    // single held key: latency DB+3 edges, one symbol only
    reset = 1'b0;
    kb.i_btn = 4'b0100;
    step(7);
    chk("lat_before", kb.o_sym_valid, 0);
    step(1);
    chk("lat_valid", kb.o_sym_valid, 1);
    chk("lat_code",  kb.o_sym_code, 2);
    chk("lat_enter", kb.o_sym_is_enter, 0);
    chk("lat_count", kb.o_sym_count, 1);
    step(20);
    chk("held_count", kb.o_sym_count, 1);
    kb.i_btn = '0;
    step(10);
    pop1();
    chk("drain_count", kb.o_sym_count, 0);

    // bounce shorter than the debounce window
    for (int i = 0; i < 10; i++) begin
      kb.i_btn[0] = (i % 2 == 0);
      step(2);
    end
    kb.i_btn = '0;
    step(15);
    chk("bounce_count", kb.o_sym_count, 0);

    // simultaneous keys, then enter
    kb.i_btn = 4'b1010;
    step(12);
    chk("prio_count", kb.o_sym_count, 1);
    chk("prio_code",  kb.o_sym_code, 1);
    kb.i_btn = '0;
    step(10);
    press(5'b10000);
    chk("enter_count", kb.o_sym_count, 2);
    pop1();
    chk("enter_flag", kb.o_sym_is_enter, 1);
    chk("enter_code", kb.o_sym_code, 0);
    pop1();
    chk("enter_drained", kb.o_sym_count, 0);

    // overflow on fifth press, then clear
    press(5'b01000);
    press(5'b00010);
    press(5'b00100);
    press(5'b00001);
    press(5'b10000);
    chk("ovf_count", kb.o_sym_count, 4);
    chk("ovf_flag",  kb.o_overflow, 1);
    chk("ovf_head",  kb.o_sym_code, 3);
    kb.i_clr_ovf = 1'b1;
    step(1);
    kb.i_clr_ovf = 1'b0;
    chk("ovf_clear", kb.o_overflow, 0);

    // push and pop on the same edge while full
    kb.i_btn = 4'b0100;
    budget = 0;
    while (!m_pend && budget < 30) begin
      step(1);
      budget++;
    end
    chk("pend_in_time", (budget < 30) ? 1 : 0, 1);
    kb.i_sym_ready = 1'b1;
    step(1);
    kb.i_sym_ready = 1'b0;
    chk("fullpp_count", kb.o_sym_count, 4);
    chk("fullpp_ovf",   kb.o_overflow, 0);
    kb.i_btn = '0;
    step(10);
    exp_codes = '{1, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      chk("fullpp_order", kb.o_sym_code, exp_codes[i]);
      pop1();
    end
    chk("fullpp_empty", kb.o_sym_count, 0);

    // reset with buffered symbols and a key held through release
    press(5'b00010);
    press(5'b00100);
    press(5'b01000);
    chk("pre_rst_count", kb.o_sym_count, 3);
    kb.i_btn = 4'b0001;
    step(3);
    reset = 1'b1;
    #1;
    chk("rst_now_valid", kb.o_sym_valid, 0);
    chk("rst_now_count", kb.o_sym_count, 0);
    step(2);
    reset = 1'b0;
    step(7);
    chk("rerun_before", kb.o_sym_valid, 0);
    step(1);
    chk("rerun_valid", kb.o_sym_valid, 1);
    chk("rerun_code",  kb.o_sym_code, 0);
    chk("rerun_count", kb.o_sym_count, 1);
    kb.i_btn = '0;
    step(10);
    pop1();

    // random keys, ready, clears and occasional resets against the model
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 11) == 0) begin
          if (k == 4) kb.i_btn_enter = ~kb.i_btn_enter;
          else        kb.i_btn[k] = ~kb.i_btn[k];
        end
      end
      kb.i_sym_ready = ($urandom_range(0, 5) == 0);
      kb.i_clr_ovf   = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 400) == 0) begin
        reset = 1'b1;
        step(2);
        reset = 1'b0;
      end
      step(1);
    end
    kb.i_btn = '0; kb.i_btn_enter = 1'b0; kb.i_sym_ready = 1'b0; kb.i_clr_ovf = 1'b0;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/guess_keypad.md
GUESS_KEYPAD -- requirements
Module: guess_keypad

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive stable cycles required before a debounced key changes state (legal 2..65535).
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 4, meaning symbol buffer entries (power of two, 2..16).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 btn  input  4  raw digit push-buttons; btn[0]..btn[3] are keys I1..I4; asynchronous, bouncing, active-high.
REQ-006 btn_enter  input  1  raw enter push-button; asynchronous, bouncing, active-high.
REQ-007 clr_ovf  input  1  synchronous clear of overflow flag.
REQ-008 sym_ready  input  1  game core accepts the head symbol.
REQ-009 sym_valid  output  1  head symbol present.
REQ-010 sym_code  output  2  digit index 0..3 (I1..I4); 0 when sym_is_enter=1.
REQ-011 sym_is_enter  output  1  head symbol is an enter event.
REQ-012 sym_count  output  clog2(FIFO_DEPTH)+1  buffer occupancy.
REQ-013 overflow  output  1  sticky flag: a symbol was dropped because the buffer was full.

Function
REQ-014 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Each synchronized input SHALL have its own debounce counter; the counter increments each cycle the synchronized value differs from the debounced value and clears to 0 on any cycle they agree.
REQ-016 The debounced value SHALL flip on the edge where the counter would reach DEBOUNCE_CYCLES; the counter clears on that same edge.
REQ-017 A key press event SHALL be the rising edge of the OR of all 5 debounced keys, qualified by lockout clear.
REQ-018 On an event, the encoded key SHALL follow fixed priority I1 > I2 > I3 > I4 > enter among debounced-high keys; lower-priority simultaneous keys are ignored.
REQ-019 An event SHALL set lockout; lockout clears only when all 5 debounced keys are 0; no further events while lockout is set (one symbol per press, no auto-repeat).
REQ-020 An event SHALL push {is_enter, code} into the FIFO on the edge following the debounced rising edge.
REQ-021 Latency: with a raw input cleanly high from edge 0 onward, sym_valid SHALL be high after edge DEBOUNCE_CYCLES+3 when the FIFO was empty.
REQ-022 sym_valid SHALL equal (sym_count != 0); sym_code/sym_is_enter SHALL show the head entry and stay stable while sym_valid=1 and sym_ready=0.
REQ-023 A pop SHALL occur on an edge where sym_valid=1 and sym_ready=1; sym_ready while empty has no effect.
REQ-024 Push when full without a same-cycle pop SHALL drop the symbol, leave contents unchanged, and set overflow.
REQ-025 Push and pop in the same cycle SHALL both take effect at any occupancy, including full (no overflow) and empty-is-impossible-for-pop.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; sym_count SHALL range 0..FIFO_DEPTH and never wrap.
REQ-027 overflow SHALL clear on a cycle with clr_ovf=1 unless a drop occurs in the same cycle, in which case it stays set.

Reset
REQ-028 While reset=1: synchronizers, debounced values, counters, lockout, pointers cleared; sym_valid=0, sym_code=0, sym_is_enter=0, sym_count=0, overflow=0.
REQ-029 Reset mid-debounce or mid-transfer SHALL discard pending and buffered symbols; a key held through reset release SHALL be re-debounced and produce one symbol after DEBOUNCE_CYCLES+3 edges.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-030 btn[2] high from edge 0, sym_ready=0 -> sym_valid=1, sym_code=2, sym_is_enter=0 after edge 7; sym_count=1; one symbol only while held.
REQ-031 btn[0] toggling every 2 cycles for 20 cycles then low -> no symbol; sym_count=0.
REQ-032 btn[1] and btn[3] rise same cycle -> one symbol, code=1; release both, press btn_enter -> second symbol is_enter=1, code=0.
REQ-033 Five separate presses with sym_ready=0 -> sym_count=4, overflow=1, head code = first press; clr_ovf pulse -> overflow=0.
REQ-034 FIFO full, sym_ready=1 on the same edge as a new push -> sym_count stays 4, overflow stays 0, new symbol at tail.
REQ-035 reset pulsed with sym_count=3 and btn[0] held -> sym_valid=0 immediately; after release of reset, one symbol code=0 after edge 7.
